// File: rtl/traffic_signal_monitor.sv
// Safety monitor and lamp driver for the highway/country light controller.
// Checks both code streams and falls back to flashing red on any violation.
module traffic_signal_monitor #(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MIN_ALLRED = 1,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       ack,
    output logic [2:0] hwy_lamp,
    output logic [2:0] cntry_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic {S_NORMAL, S_FAULT} state_e;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] ILL = 2'd3;

    localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MIN_AR = CNT_W'(MIN_ALLRED);
    localparam logic [CNT_W-1:0] FL_END = CNT_W'(FLASH_HALF - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [2:0] lamp_of(input logic [1:0] code);
        logic [2:0] l;
        case (code)
            YEL:     l = 3'b010;
            GRN:     l = 3'b001;
            default: l = 3'b100;
        endcase
        return l;
    endfunction

    function automatic logic bad_tr(input logic [1:0] p, input logic [1:0] n);
        return (p == GRN && n == RED) || (p == RED && n == YEL) ||
               (p == YEL && n == GRN);
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       h_q, h_d, c_q, c_d;
    logic [1:0]       h_p_q, h_p_d, c_p_q, c_p_d;
    logic             smp_q, smp_d;
    logic             valid_p_q, valid_p_d;
    logic [CNT_W-1:0] hy_q, hy_d, cy_q, cy_d, ar_q, ar_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
    logic             fl_on_q, fl_on_d;
    logic [2:0]       code_q, code_d;
    logic [2:0]       hl_q, hl_d, cl_q, cl_d;

    logic       ill, conf, bseq, syel, sclr;
    logic [2:0] hit;

    always_comb begin
        ill  = (h_q == ILL) || (c_q == ILL);
        conf = (h_q != RED) && (c_q != RED);
        bseq = valid_p_q && (bad_tr(h_p_q, h_q) || bad_tr(c_p_q, c_q));
        syel = valid_p_q &&
               ((h_p_q == YEL && h_q == RED && hy_q < MIN_Y) ||
                (c_p_q == YEL && c_q == RED && cy_q < MIN_Y));
        sclr = valid_p_q &&
               ((h_p_q == RED && h_q == GRN && ar_q < MIN_AR) ||
                (c_p_q == RED && c_q == GRN && ar_q < MIN_AR));
        // Lowest cause code wins when several checks fire together
        if (ill)       hit = 3'd1;
        else if (conf) hit = 3'd2;
        else if (bseq) hit = 3'd3;
        else if (syel) hit = 3'd4;
        else if (sclr) hit = 3'd5;
        else           hit = 3'd0;
    end

    always_comb begin
        state_d   = state_q;
        h_d       = hwy;
        c_d       = cntry;
        h_p_d     = h_q;
        c_p_d     = c_q;
        smp_d     = 1'b1;
        valid_p_d = smp_q;
        hy_d      = (smp_q && h_q == YEL) ? sat_inc(hy_q) : '0;
        cy_d      = (smp_q && c_q == YEL) ? sat_inc(cy_q) : '0;
        ar_d      = (smp_q && h_q == RED && c_q == RED) ? sat_inc(ar_q) : '0;
        fl_cnt_d  = fl_cnt_q;
        fl_on_d   = fl_on_q;
        code_d    = code_q;
        hl_d      = hl_q;
        cl_d      = cl_q;
        unique case (state_q)
            S_NORMAL: begin
                if (hit != 3'd0) begin
                    state_d  = S_FAULT;
                    code_d   = hit;
                    fl_cnt_d = '0;
                    fl_on_d  = 1'b1;
                end else begin
                    hl_d = lamp_of(h_q);
                    cl_d = lamp_of(c_q);
                end
            end
            S_FAULT: begin
                if (ack && h_q == RED && c_q == RED) begin
                    state_d   = S_NORMAL;
                    code_d    = 3'd0;
                    valid_p_d = 1'b0;
                    hy_d      = '0;
                    cy_d      = '0;
                    ar_d      = '0;
                    hl_d      = lamp_of(h_q);
                    cl_d      = lamp_of(c_q);
                end else if (fl_cnt_q == FL_END) begin
                    fl_cnt_d = '0;
                    fl_on_d  = !fl_on_q;
                end else begin
                    fl_cnt_d = fl_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_NORMAL;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_NORMAL;
            h_q       <= RED;
            c_q       <= RED;
            h_p_q     <= RED;
            c_p_q     <= RED;
            smp_q     <= 1'b0;
            valid_p_q <= 1'b0;
            hy_q      <= '0;
            cy_q      <= '0;
            ar_q      <= '0;
            fl_cnt_q  <= '0;
            fl_on_q   <= 1'b1;
            code_q    <= 3'd0;
            hl_q      <= 3'b100;
            cl_q      <= 3'b100;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            c_q       <= c_d;
            h_p_q     <= h_p_d;
            c_p_q     <= c_p_d;
            smp_q     <= smp_d;
            valid_p_q <= valid_p_d;
            hy_q      <= hy_d;
            cy_q      <= cy_d;
            ar_q      <= ar_d;
            fl_cnt_q  <= fl_cnt_d;
            fl_on_q   <= fl_on_d;
            code_q    <= code_d;
            hl_q      <= hl_d;
            cl_q      <= cl_d;
        end
    end

    assign fault      = (state_q == S_FAULT);
    assign fault_code = code_q;
    assign hwy_lamp   = fault ? (fl_on_q ? 3'b100 : 3'b000) : hl_q;
    assign cntry_lamp = fault ? (fl_on_q ? 3'b100 : 3'b000) : cl_q;

endmodule
